// File: rtl/esfa_pkg.sv
// Shared opcodes, sequencer states and bus defaults for the ESFA cell array.
package esfa_pkg;

  localparam logic [2:0] OP_UPDATE        = 3'd0;
  localparam logic [2:0] OP_LOOKUP        = 3'd1;
  localparam logic [2:0] OP_ENCODE        = 3'd2;
  localparam logic [2:0] OP_CONGRUE_UP    = 3'd3;
  localparam logic [2:0] OP_CONGRUE_DOWN  = 3'd4;
  localparam logic [2:0] OP_MARK_AVAIL    = 3'd5;
  localparam logic [2:0] OP_ENRANK        = 3'd6;
  localparam logic [2:0] OP_ILLEGAL       = 3'd7;

  localparam logic [7:0] IDLE_SEL_DEFAULT   = 8'hFF;
  localparam logic [6:0] WRITE_MASK_DEFAULT = 7'b1111101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PROBE  = 3'd1,
    EVAL   = 3'd2,
    COMMIT = 3'd3,
    RESP   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/esfa_cell_sequencer_prio.sv
// Lowest-index finder over the per-cell result bools, muxing that cell's value/context.
// Purely combinational; all outputs are zero when no bool is set.
module esfa_prio_select #(
  parameter int N_CELLS = 8
) (
  input  logic [N_CELLS-1:0]   cellBool,
  input  logic [8*N_CELLS-1:0] valueBus,
  input  logic [8*N_CELLS-1:0] ctxBus,
  output logic                 found,
  output logic [5:0]           idx,
  output logic [7:0]           value,
  output logic [7:0]           ctx
);

  // Scan downwards so the last hit written is the lowest index.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    value = '0;
    ctx   = '0;
    for (int i = N_CELLS - 1; i >= 0; i--) begin
      if (cellBool[i]) begin
        found = 1'b1;
        idx   = 6'(i);
        value = valueBus[8*i +: 8];
        ctx   = ctxBus[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/esfa_cell_sequencer.sv
// Probe/commit sequencer for the ESFA cell array; response 4 cycles after accept (3 lookup, 1 illegal),
// one op in flight, response held until rsp_ready. ESFA_SEQ_PERF_EN adds perf_ops/perf_writes counters.
module esfa_cell_sequencer
  import esfa_pkg::*;
#(
  parameter int         N_CELLS    = 8,
  parameter logic [7:0] IDLE_SEL   = IDLE_SEL_DEFAULT,
  parameter logic [6:0] WRITE_MASK = WRITE_MASK_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [7:0]           cmd_handle,
  input  logic [7:0]           cmd_index,
  input  logic [7:0]           cmd_value,
  input  logic [7:0]           cmd_metadata,
  input  logic                 cmd_is_meta,
  output logic [7:0]           cell_selector,
  output logic                 cell_will_write,
  output logic [7:0]           cell_handle,
  output logic [7:0]           cell_index,
  output logic [7:0]           cell_value,
  output logic [7:0]           cell_metadata,
  output logic                 cell_is_meta,
  input  logic [N_CELLS-1:0]   cell_bool,
  input  logic [8*N_CELLS-1:0] cell_value_bus,
  input  logic [8*N_CELLS-1:0] cell_context_bus,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_found,
  output logic [5:0]           rsp_cell,
  output logic [7:0]           rsp_value,
  output logic [7:0]           rsp_context,
  output logic                 rsp_err
`ifdef ESFA_SEQ_PERF_EN
  ,
  output logic [15:0]          perf_ops,
  output logic [15:0]          perf_writes
`endif
);

  if (N_CELLS < 1 || N_CELLS > 64) begin : gBadCellCount
    $error("esfa_cell_sequencer: N_CELLS must be in 1..64");
  end

  seq_state_t state;
  logic [2:0] opReg;
  logic       prioFound;
  logic [5:0] prioIdx;
  logic [7:0] prioValue;
  logic [7:0] prioCtx;

  // Opcode 7 never reaches the commit decision, so the extra bit only pads the index range.
  logic [7:0] writeMaskExt;
  assign writeMaskExt = {1'b0, WRITE_MASK};

  esfa_prio_select #(.N_CELLS(N_CELLS)) uPrio (
    .cellBool (cell_bool),
    .valueBus (cell_value_bus),
    .ctxBus   (cell_context_bus),
    .found    (prioFound),
    .idx      (prioIdx),
    .value    (prioValue),
    .ctx      (prioCtx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      opReg           <= '0;
      cmd_ready       <= 1'b1;
      rsp_valid       <= 1'b0;
      rsp_found       <= 1'b0;
      rsp_cell        <= '0;
      rsp_value       <= '0;
      rsp_context     <= '0;
      rsp_err         <= 1'b0;
      cell_selector   <= IDLE_SEL;
      cell_will_write <= 1'b0;
      cell_handle     <= '0;
      cell_index      <= '0;
      cell_value      <= '0;
      cell_metadata   <= '0;
      cell_is_meta    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            opReg     <= cmd_op;
            cmd_ready <= 1'b0;
            if (cmd_op == OP_ILLEGAL) begin
              state       <= RESP;
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_found   <= 1'b0;
              rsp_cell    <= '0;
              rsp_value   <= '0;
              rsp_context <= '0;
            end else begin
              state         <= PROBE;
              rsp_err       <= 1'b0;
              cell_selector <= {5'b0, cmd_op};
              cell_handle   <= cmd_handle;
              cell_index    <= cmd_index;
              cell_value    <= cmd_value;
              cell_metadata <= cmd_metadata;
              cell_is_meta  <= cmd_is_meta;
            end
          end
        end
        PROBE: begin
          state <= EVAL;
        end
        EVAL: begin
          rsp_found   <= prioFound;
          rsp_cell    <= prioIdx;
          rsp_value   <= prioValue;
          rsp_context <= prioCtx;
          if (writeMaskExt[opReg]) begin
            state           <= COMMIT;
            cell_will_write <= 1'b1;
          end else begin
            state         <= RESP;
            rsp_valid     <= 1'b1;
            cell_selector <= IDLE_SEL;
            cell_handle   <= '0;
            cell_index    <= '0;
            cell_value    <= '0;
            cell_metadata <= '0;
            cell_is_meta  <= 1'b0;
          end
        end
        COMMIT: begin
          state           <= RESP;
          rsp_valid       <= 1'b1;
          cell_will_write <= 1'b0;
          cell_selector   <= IDLE_SEL;
          cell_handle     <= '0;
          cell_index      <= '0;
          cell_value      <= '0;
          cell_metadata   <= '0;
          cell_is_meta    <= 1'b0;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state           <= IDLE;
          cmd_ready       <= 1'b1;
          rsp_valid       <= 1'b0;
          cell_will_write <= 1'b0;
          cell_selector   <= IDLE_SEL;
        end
      endcase
    end
  end

`ifdef ESFA_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_ops    <= '0;
      perf_writes <= '0;
    end else begin
      if (state == IDLE && cmd_valid && cmd_op != OP_ILLEGAL && perf_ops != 16'hFFFF)
        perf_ops <= perf_ops + 16'd1;
      if (state == COMMIT && perf_writes != 16'hFFFF)
        perf_writes <= perf_writes + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_esfa_cell_sequencer.sv
// Directed bench for esfa_cell_sequencer: lookup, update, no-match, illegal, backpressure, reset mid-commit.
module tb_esfa_cell_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_handle, cmd_index, cmd_value, cmd_metadata;
  logic        cmd_is_meta;
  logic [7:0]  cell_selector;
  logic        cell_will_write;
  logic [7:0]  cell_handle, cell_index, cell_value, cell_metadata;
  logic        cell_is_meta;
  logic [7:0]  cell_bool;
  logic [63:0] cell_value_bus, cell_context_bus;
  logic        rsp_valid, rsp_ready, rsp_found, rsp_err;
  logic [5:0]  rsp_cell;
  logic [7:0]  rsp_value, rsp_context;
`ifdef ESFA_SEQ_PERF_EN
  logic [15:0] perf_ops, perf_writes;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  esfa_cell_sequencer #(.N_CELLS(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_handle       (cmd_handle),
    .cmd_index        (cmd_index),
    .cmd_value        (cmd_value),
    .cmd_metadata     (cmd_metadata),
    .cmd_is_meta      (cmd_is_meta),
    .cell_selector    (cell_selector),
    .cell_will_write  (cell_will_write),
    .cell_handle      (cell_handle),
    .cell_index       (cell_index),
    .cell_value       (cell_value),
    .cell_metadata    (cell_metadata),
    .cell_is_meta     (cell_is_meta),
    .cell_bool        (cell_bool),
    .cell_value_bus   (cell_value_bus),
    .cell_context_bus (cell_context_bus),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_found        (rsp_found),
    .rsp_cell         (rsp_cell),
    .rsp_value        (rsp_value),
    .rsp_context      (rsp_context),
    .rsp_err          (rsp_err)
`ifdef ESFA_SEQ_PERF_EN
    ,
    .perf_ops         (perf_ops),
    .perf_writes      (perf_writes)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1ns past it so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] h, input logic [7:0] idx,
                       input logic [7:0] v);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_handle = h;
    cmd_index  = idx;
    cmd_value  = v;
    step();
    cmd_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_handle = '0; cmd_index = '0;
    cmd_value = '0; cmd_metadata = '0; cmd_is_meta = 1'b0; rsp_ready = 1'b1;
    cell_bool = '0; cell_value_bus = '0; cell_context_bus = '0;
    step();
    step();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_selector", cell_selector, 8'hFF);
    check("rst_will_write", cell_will_write, 0);
    check("rst_rsp_found", rsp_found, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_cell_handle", cell_handle, 0);
    rst_n = 1'b1;
    step();

    // Lookup: cells 2 and 5 match, cell 2 must win.
    cell_bool = 8'b0010_0100;
    cell_value_bus   = 64'h0000_7700_003C_0000;
    cell_context_bus = 64'h0000_9900_005A_0000;
    issue(3'd1, 8'h05, 8'h00, 8'h00);
    check("lk_t1_sel", cell_selector, 8'h01);
    check("lk_t1_handle", cell_handle, 8'h05);
    check("lk_t1_ww", cell_will_write, 0);
    check("lk_t1_cmd_ready", cmd_ready, 0);
    check("lk_t1_rsp_valid", rsp_valid, 0);
    step();
    check("lk_t2_sel", cell_selector, 8'h01);
    check("lk_t2_ww", cell_will_write, 0);
    check("lk_t2_rsp_valid", rsp_valid, 0);
    step();
    check("lk_t3_rsp_valid", rsp_valid, 1);
    check("lk_t3_found", rsp_found, 1);
    check("lk_t3_cell", rsp_cell, 2);
    check("lk_t3_value", rsp_value, 8'h3C);
    check("lk_t3_ctx", rsp_context, 8'h5A);
    check("lk_t3_err", rsp_err, 0);
    check("lk_t3_ww", cell_will_write, 0);
    check("lk_t3_sel_parked", cell_selector, 8'hFF);
    step();
    check("lk_done_rsp_valid", rsp_valid, 0);
    check("lk_done_cmd_ready", cmd_ready, 1);

    // Update: cells 0 and 1 match; commit pass on T+3.
    cell_bool = 8'b0000_0011;
    cell_value_bus   = 64'h0000_0000_0000_2211;
    cell_context_bus = 64'h0000_0000_0000_B2B1;
    issue(3'd0, 8'h01, 8'h04, 8'hAA);
    check("up_t1_sel", cell_selector, 8'h00);
    check("up_t1_index", cell_index, 8'h04);
    check("up_t1_value", cell_value, 8'hAA);
    check("up_t1_ww", cell_will_write, 0);
    step();
    check("up_t2_sel", cell_selector, 8'h00);
    check("up_t2_ww", cell_will_write, 0);
    step();
    check("up_t3_sel", cell_selector, 8'h00);
    check("up_t3_ww", cell_will_write, 1);
    check("up_t3_rsp_valid", rsp_valid, 0);
    step();
    check("up_t4_rsp_valid", rsp_valid, 1);
    check("up_t4_ww", cell_will_write, 0);
    check("up_t4_sel_parked", cell_selector, 8'hFF);
    check("up_t4_found", rsp_found, 1);
    check("up_t4_cell", rsp_cell, 0);
    check("up_t4_value", rsp_value, 8'h11);
    check("up_t4_ctx", rsp_context, 8'hB1);
    step();

    // markAvailable with no match: response zeroed despite busy value buses.
    cell_bool = 8'h00;
    cell_value_bus   = {8{8'hFF}};
    cell_context_bus = {8{8'hEE}};
    issue(3'd5, 8'h10, 8'h20, 8'h30);
    check("ma_t1_sel", cell_selector, 8'h05);
    step();
    step();
    check("ma_t3_ww", cell_will_write, 1);
    step();
    check("ma_t4_rsp_valid", rsp_valid, 1);
    check("ma_t4_found", rsp_found, 0);
    check("ma_t4_cell", rsp_cell, 0);
    check("ma_t4_value", rsp_value, 0);
    check("ma_t4_ctx", rsp_context, 0);
    step();

    // Illegal opcode: immediate error response, bus never leaves idle.
    issue(3'd7, 8'h00, 8'h00, 8'h00);
    check("il_t1_rsp_valid", rsp_valid, 1);
    check("il_t1_err", rsp_err, 1);
    check("il_t1_found", rsp_found, 0);
    check("il_t1_sel", cell_selector, 8'hFF);
    check("il_t1_ww", cell_will_write, 0);
    step();
    check("il_done_rsp_valid", rsp_valid, 0);
    check("il_done_sel", cell_selector, 8'hFF);

    // Backpressure: lookup hitting cell 7, host stalls 10 cycles with a new command pending.
    rsp_ready = 1'b0;
    cell_bool = 8'b1000_0000;
    cell_value_bus   = 64'hC700_0000_0000_0000;
    cell_context_bus = 64'h7C00_0000_0000_0000;
    issue(3'd1, 8'h33, 8'h00, 8'h00);
    step();
    step();
    check("bp_rsp_valid", rsp_valid, 1);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_handle = 8'h44; cmd_index = 8'h09; cmd_value = 8'h55;
    cell_bool = 8'h00;
    cell_value_bus = '0;
    cell_context_bus = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_cell", rsp_cell, 7);
      check("bp_hold_value", rsp_value, 8'hC7);
      check("bp_hold_ctx", rsp_context, 8'h7C);
      check("bp_hold_cmd_ready", cmd_ready, 0);
      check("bp_hold_sel", cell_selector, 8'hFF);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_release_rsp_valid", rsp_valid, 0);
    check("bp_release_cmd_ready", cmd_ready, 1);
    check("bp_release_sel", cell_selector, 8'hFF);
    step();
    cmd_valid = 1'b0;
    check("bp_second_sel", cell_selector, 8'h00);
    check("bp_second_handle", cell_handle, 8'h44);
    step();
    step();
    check("rc_commit_ww", cell_will_write, 1);
`ifdef ESFA_SEQ_PERF_EN
    check("perf_ops_count", perf_ops, 5);
    check("perf_writes_count", perf_writes, 2);
`endif

    // Reset in COMMIT aborts the op.
    rst_n = 1'b0;
    step();
    check("rc_ww", cell_will_write, 0);
    check("rc_rsp_valid", rsp_valid, 0);
    check("rc_cmd_ready", cmd_ready, 1);
    check("rc_sel", cell_selector, 8'hFF);
`ifdef ESFA_SEQ_PERF_EN
    check("rc_perf_ops", perf_ops, 0);
    check("rc_perf_writes", perf_writes, 0);
`endif
    rst_n = 1'b1;
    step();
    step();
    step();
    check("rc_no_rsp", rsp_valid, 0);
    check("rc_idle_ready", cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
